// File: rtl/prng_pkg.sv
// Shared types and constants for the range-limited PRNG.
// State enum, default LFSR constants and a saturating counter helper.
package prng_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    HOLD
  } state_e;

  localparam logic [15:0] DEF_TAPS = 16'hB400;
  localparam logic [15:0] DEF_SEED = 16'hACE1;

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Free-running Galois LFSR with synchronous reseed.
// A zero seed is replaced by SEED so the state never locks up.
module lfsr_core
  import prng_pkg::*;
#(
  parameter int              WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS = DEF_TAPS,
  parameter logic [WIDTH-1:0] SEED = DEF_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0] state_o
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic [WIDTH-1:0] shift;

  assign shift = (state_q >> 1)
               ^ (state_q[0] ? TAPS : '0);

  always_comb begin
    state_d = shift;
    if (load_i) begin
      state_d = (seed_i == '0) ? SEED : seed_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/prng_range_gen.sv
// Unbiased index source in [0, N_OUT-1] with bounded rejection sampling.
// Define PRNG_NO_REPEAT_EN to forbid two consecutive equal indices.
module prng_range_gen
  import prng_pkg::*;
#(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] TAPS    = DEF_TAPS,
  parameter logic [WIDTH-1:0] SEED    = DEF_SEED,
  parameter int               N_OUT   = 6,
  parameter int               MAX_TRY = 8,
  localparam int              OUT_W   = $clog2(N_OUT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_value,
  input  logic             req_valid,
  output logic             req_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [7:0]       fallback_cnt,
  output logic [WIDTH-1:0] lfsr_state
);

  localparam int RW = (MAX_TRY > 1) ? $clog2(MAX_TRY) : 1;
  localparam logic [RW-1:0]  LAST = RW'(MAX_TRY - 1);
  localparam logic [OUT_W:0] NMAX = (OUT_W + 1)'(N_OUT);

  state_e           state_q, state_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             vld_q, vld_d;
  logic [7:0]       cnt_q, cnt_d;

  logic [OUT_W-1:0] cand;
  logic             in_rng;
  logic [OUT_W-1:0] fb_raw;
  logic             ok;
  logic [OUT_W-1:0] fb;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst),
    .load_i  (seed_load),
    .seed_i  (seed_value),
    .state_o (lfsr_state)
  );

  assign cand   = lfsr_state[OUT_W-1:0];
  assign in_rng = {1'b0, cand} < NMAX;
  // 2**OUT_W < 2*N_OUT, so one subtraction folds any reject into range
  assign fb_raw = in_rng ? cand
                : OUT_W'({1'b0, cand} - NMAX);

`ifdef PRNG_NO_REPEAT_EN
  logic [OUT_W-1:0] prev_q;

  assign ok = in_rng && (cand != prev_q);
  assign fb = (fb_raw != prev_q) ? fb_raw
            : (({1'b0, fb_raw} + 1'b1) == NMAX) ? '0
            : fb_raw + OUT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= '0;
    end else if (vld_q && out_ready) begin
      prev_q <= data_q;
    end
  end
`else
  assign ok = in_rng;
  assign fb = fb_raw;
`endif

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    data_d  = data_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = DRAW;
          retry_d = '0;
        end
      end
      DRAW: begin
        if (ok) begin
          data_d  = cand;
          vld_d   = 1'b1;
          state_d = HOLD;
        end else if (retry_q == LAST) begin
          data_d  = fb;
          vld_d   = 1'b1;
          cnt_d   = sat_inc8(cnt_q);
          state_d = HOLD;
        end else begin
          retry_d = retry_q + 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      retry_q <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign out_valid    = vld_q;
  assign out_data     = data_q;
  assign fallback_cnt = cnt_q;

endmodule

// File: tb/tb_prng_range_gen.sv
// Bench for prng_range_gen: seed tables, LFSR scan, fallback vectors,
// randomized requests against a transaction-level model, reset cases.
module tb_prng_range_gen;

  localparam int          N    = 6;
  localparam int          MT   = 8;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] TAPS = 16'hB400;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        seed_load = 1'b0, req_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] seed_value = '0;
  logic        req_ready, out_valid;
  logic [2:0]  out_data;
  logic [7:0]  fallback_cnt;
  logic [15:0] lfsr_state;

  logic        seed_load1 = 1'b0, req_valid1 = 1'b0, out_ready1 = 1'b0;
  logic [15:0] seed_value1 = '0;
  logic        req_ready1, out_valid1;
  logic [2:0]  out_data1;
  logic [7:0]  fallback_cnt1;
  logic [15:0] lfsr_state1;

  prng_range_gen dut (
    .clk          (clk),
    .rst          (rst),
    .seed_load    (seed_load),
    .seed_value   (seed_value),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .fallback_cnt (fallback_cnt),
    .lfsr_state   (lfsr_state)
  );

  prng_range_gen #(.MAX_TRY(1)) dut1 (
    .clk          (clk),
    .rst          (rst),
    .seed_load    (seed_load1),
    .seed_value   (seed_value1),
    .req_valid    (req_valid1),
    .req_ready    (req_ready1),
    .out_valid    (out_valid1),
    .out_ready    (out_ready1),
    .out_data     (out_data1),
    .fallback_cnt (fallback_cnt1),
    .lfsr_state   (lfsr_state1)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] m_lfsr;
  logic [7:0]  m_fb;
`ifdef PRNG_NO_REPEAT_EN
  logic [2:0]  m_prev;
`endif
  bit          rnd_seed = 1'b0;

  typedef struct packed {
    logic [15:0] seed;
    logic [15:0] lfsr;
  } seed_vec_t;

  typedef struct packed {
    logic [15:0] seed;
    logic [15:0] lfsr;
    logic [2:0]  data;
    logic [7:0]  fb;
  } fb_vec_t;

  seed_vec_t tab0[5];
  fb_vec_t   tab1[7];

  function automatic logic [15:0] nxt(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : 16'h0000);
  endfunction

  function automatic bit acc(input logic [2:0] c);
`ifdef PRNG_NO_REPEAT_EN
    return (int'(c) < N) && (c != m_prev);
`else
    return int'(c) < N;
`endif
  endfunction

  function automatic logic [2:0] fbk(input logic [2:0] c);
    int f;
    f = (int'(c) >= N) ? int'(c) - N : int'(c);
`ifdef PRNG_NO_REPEAT_EN
    if (f == int'(m_prev)) f = (f + 1 == N) ? 0 : f + 1;
`endif
    return 3'(f);
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    m_lfsr = seed_load
           ? ((seed_value == 16'h0) ? SEED : seed_value)
           : nxt(m_lfsr);
    #1;
    if (rnd_seed) begin
      seed_load  = ($urandom_range(15) == 0);
      seed_value = ($urandom_range(7) == 0) ? 16'h0 : 16'($urandom);
    end
  endtask

  task automatic model_reset();
    m_lfsr = SEED;
    m_fb   = 8'd0;
`ifdef PRNG_NO_REPEAT_EN
    m_prev = 3'd0;
`endif
  endtask

  // One full request: accept, draw (model picks value and latency), hold, hand over.
  task automatic run_req(input int hold, input bit poke,
                         output logic [2:0] v);
    logic [2:0] c, e;
    int         tries;
    bit         done;
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    tries = 0;
    done  = 1'b0;
    e     = '0;
    while (!done) begin
      c = m_lfsr[2:0];
      if (acc(c)) begin
        e = c;
        done = 1'b1;
      end else if (tries == MT - 1) begin
        e = fbk(c);
        done = 1'b1;
        if (m_fb != 8'hFF) m_fb++;
      end else begin
        tries++;
      end
      step();
      if (!done) chk("draw_valid_low", out_valid, 0);
    end
    chk("out_valid", out_valid, 1);
    chk("out_data", out_data, e);
    chk("out_range", out_data < 3'(N), 1);
    chk("fallback_cnt", fallback_cnt, m_fb);
    for (int i = 0; i < hold; i++) begin
      if (poke) req_valid = 1'b1;
      step();
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, e);
      chk("hold_req_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("release_valid", out_valid, 0);
    chk("release_idle", req_ready, 1);
`ifdef PRNG_NO_REPEAT_EN
    m_prev = e;
`endif
    v = e;
  endtask

  initial begin
    logic [2:0] v, last;
    int         hist[N];
    int         reps;
    bit         seen;

    tab0[0] = '{16'h0000, 16'hACE1};
    tab0[1] = '{16'h0001, 16'h0001};
    tab0[2] = '{16'hFFFF, 16'hFFFF};
    tab0[3] = '{16'h8000, 16'h8000};
    tab0[4] = '{16'hACE1, 16'hACE1};

`ifdef PRNG_NO_REPEAT_EN
    tab1[0] = '{16'h0000, 16'hACE1, 3'd1, 8'd0};
    tab1[1] = '{16'h0007, 16'h0007, 3'd2, 8'd1};
    tab1[2] = '{16'h0006, 16'h0006, 3'd0, 8'd2};
    tab1[3] = '{16'h0005, 16'h0005, 3'd5, 8'd2};
    tab1[4] = '{16'hFFF8, 16'hFFF8, 3'd0, 8'd2};
    tab1[5] = '{16'h0008, 16'h0008, 3'd1, 8'd3};
    tab1[6] = '{16'h000F, 16'h000F, 3'd2, 8'd4};
`else
    tab1[0] = '{16'h0000, 16'hACE1, 3'd1, 8'd0};
    tab1[1] = '{16'h0007, 16'h0007, 3'd1, 8'd1};
    tab1[2] = '{16'h0006, 16'h0006, 3'd0, 8'd2};
    tab1[3] = '{16'h0005, 16'h0005, 3'd5, 8'd2};
    tab1[4] = '{16'hFFF8, 16'hFFF8, 3'd0, 8'd2};
    tab1[5] = '{16'h0008, 16'h0008, 3'd0, 8'd2};
    tab1[6] = '{16'h000F, 16'h000F, 3'd1, 8'd3};
`endif

    // reset state, no clock edge needed
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_fb", fallback_cnt, 0);
    chk("rst_lfsr", lfsr_state, SEED);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    chk("rel_lfsr", lfsr_state, SEED);
    chk("rel_ready", req_ready, 1);

    for (int i = 0; i < 5; i++) begin
      seed_load  = 1'b1;
      seed_value = tab0[i].seed;
      step();
      seed_load = 1'b0;
      chk("seed_load", lfsr_state, tab0[i].lfsr);
    end
    step();
    chk("shift_ace1", lfsr_state, 16'hE270);

    for (int i = 0; i < 30000; i++) begin
      step();
      chk("lfsr_nonzero", lfsr_state != 16'h0, 1);
      chk("lfsr_model", lfsr_state, m_lfsr);
    end

    // single-try instance: forced candidates exercise fallback directly
    for (int i = 0; i < 7; i++) begin
      chk("d1_ready", req_ready1, 1);
      seed_load1  = 1'b1;
      seed_value1 = tab1[i].seed;
      req_valid1  = 1'b1;
      step();
      seed_load1 = 1'b0;
      req_valid1 = 1'b0;
      chk("d1_lfsr", lfsr_state1, tab1[i].lfsr);
      step();
      chk("d1_valid", out_valid1, 1);
      chk("d1_data", out_data1, tab1[i].data);
      chk("d1_fb", fallback_cnt1, tab1[i].fb);
      out_ready1 = 1'b1;
      step();
      out_ready1 = 1'b0;
      chk("d1_release", out_valid1, 0);
    end

    run_req(20, 1'b1, v);

    foreach (hist[k]) hist[k] = 0;
    reps = 0;
    last = '0;
    rnd_seed = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      repeat ($urandom_range(2)) step();
      run_req(int'($urandom_range(3)), 1'b0, v);
      hist[v]++;
      if (i > 0 && v == last) reps++;
      last = v;
    end
    rnd_seed  = 1'b0;
    seed_load = 1'b0;
    // low bits of successive states overlap, so retries skew the mix; check coverage loosely
    for (int k = 0; k < N; k++) begin
      chk($sformatf("hist_%0d", k), hist[k] > 250, 1);
    end
`ifdef PRNG_NO_REPEAT_EN
    chk("no_repeats", reps, 0);
`else
    chk("repeats_seen", reps > 0, 1);
`endif

    // reset in DRAW
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk("rdraw_valid", out_valid, 0);
    chk("rdraw_ready", req_ready, 1);
    chk("rdraw_lfsr", lfsr_state, SEED);
    chk("rdraw_fb", fallback_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    chk("rdraw_rel_lfsr", lfsr_state, SEED);

    // reset in HOLD
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      step();
      seen = out_valid;
    end
    chk("rhold_reached", seen, 1);
    #1;
    rst = 1'b0;
    #1;
    chk("rhold_valid", out_valid, 0);
    chk("rhold_data", out_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    chk("rhold_rel_lfsr", lfsr_state, SEED);
    run_req(2, 1'b0, v);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
